// File: rtl/word_unpacker_if.sv
// Word-in / chunk-out handshake bundle for word_unpacker.
interface word_unpacker_if #(
    parameter int WORD_BITS  = 32,
    parameter int CHUNK_BITS = 8
);
    logic                  word_valid;
    logic [WORD_BITS-1:0]  word_in;
    logic                  word_ready;
    logic                  chunk_valid;
    logic [CHUNK_BITS-1:0] chunk_data;
    logic                  chunk_last;
    logic                  chunk_ready;
    logic                  busy;

    // Unpacker side.
    modport slave (
        input  word_valid, word_in, chunk_ready,
        output word_ready, chunk_valid, chunk_data, chunk_last, busy
    );

    // Producer/consumer side driving the unpacker.
    modport master (
        output word_valid, word_in, chunk_ready,
        input  word_ready, chunk_valid, chunk_data, chunk_last, busy
    );
endinterface

// File: rtl/word_unpacker.sv
// word_unpacker: takes one WORD_BITS word and emits it as NCHUNK chunks,
// least-significant chunk first, with back-to-back word reload on the last chunk.
module word_unpacker #(
    parameter int WORD_BITS  = 32,
    parameter int CHUNK_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    word_unpacker_if.slave    bus
);
    localparam int NCHUNK = WORD_BITS / CHUNK_BITS;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    generate
        if ((WORD_BITS % CHUNK_BITS) != 0 || NCHUNK < 2) begin : g_bad_param
            $error("word_unpacker: WORD_BITS must be a multiple of CHUNK_BITS with at least 2 chunks");
        end
    endgenerate

    logic [0:0]           state_q, state_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     count_q, count_d;

    logic chunk_valid;
    logic chunk_last;
    logic chunk_accept;

    // Output decode: chunk_data comes straight from the shift register flops.
    always_comb begin
        chunk_valid      = (state_q == ST_SEND);
        chunk_last       = chunk_valid && (count_q == CNT_LAST);
        chunk_accept     = chunk_valid && bus.chunk_ready;
        bus.chunk_valid  = chunk_valid;
        bus.chunk_last   = chunk_last;
        bus.chunk_data   = shreg_q[CHUNK_BITS-1:0];
        bus.busy         = chunk_valid;
        // Ready early on the final chunk so the next word loads without a bubble.
        bus.word_ready   = (state_q == ST_IDLE) || (chunk_accept && chunk_last);
    end

    // Next-state: load on word accept, shift on chunk accept, reload or idle after the last chunk.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.word_valid) begin
                    shreg_d = bus.word_in;
                    count_d = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (chunk_accept) begin
                    if (chunk_last) begin
                        count_d = '0;
                        if (bus.word_valid) begin
                            shreg_d = bus.word_in;
                        end else begin
                            shreg_d = '0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        shreg_d = shreg_q >> CHUNK_BITS;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any partially sent word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_word_unpacker.sv
// Scoreboard bench for word_unpacker: a 32/8 instance and a 16/4 instance.
module tb_word_unpacker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    word_unpacker_if #(.WORD_BITS(32), .CHUNK_BITS(8)) bus32 ();
    word_unpacker_if #(.WORD_BITS(16), .CHUNK_BITS(4)) bus16 ();

    word_unpacker #(.WORD_BITS(32), .CHUNK_BITS(8)) u32 (.clk(clk), .rst(rst), .bus(bus32));
    word_unpacker #(.WORD_BITS(16), .CHUNK_BITS(4)) u16 (.clk(clk), .rst(rst), .bus(bus16));

    int total = 0;
    int bad   = 0;

    logic [8:0] q32[$];  // {last, data}
    logic [4:0] q16[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the 32-bit instance: pops on every chunk handshake, checks hold under backpressure.
    logic       held32 = 1'b0;
    logic [8:0] prev32 = '0;
    always @(negedge clk) begin
        if (bus32.chunk_valid && bus32.chunk_ready) begin
            if (q32.size() == 0) begin
                total++; bad++;
                $display("FAIL chunk32_unexpected: got %h expected none", bus32.chunk_data);
            end else begin
                logic [8:0] e;
                e = q32.pop_front();
                check("chunk32", {23'd0, bus32.chunk_last, bus32.chunk_data}, {23'd0, e});
            end
        end
        if (bus32.chunk_valid && !bus32.chunk_ready) begin
            if (held32)
                check("hold32", {23'd0, bus32.chunk_last, bus32.chunk_data}, {23'd0, prev32});
            held32 = 1'b1;
            prev32 = {bus32.chunk_last, bus32.chunk_data};
        end else begin
            held32 = 1'b0;
        end
    end

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        if (bus16.chunk_valid && bus16.chunk_ready) begin
            if (q16.size() == 0) begin
                total++; bad++;
                $display("FAIL chunk16_unexpected: got %h expected none", bus16.chunk_data);
            end else begin
                logic [4:0] e;
                e = q16.pop_front();
                check("chunk16", {27'd0, bus16.chunk_last, bus16.chunk_data}, {27'd0, e});
            end
        end
    end

    // Offer a word; nexp of its chunks are expected to reach the consumer.
    task automatic offer32(input logic [31:0] w, input int nexp);
        bus32.word_valid = 1'b1;
        bus32.word_in    = w;
        for (int i = 0; i < nexp; i++)
            q32.push_back({(i == 3), w[i*8 +: 8]});
        for (int i = 0; i < 50; i++) begin
            if (bus32.word_ready) break;
            tick();
        end
        check("word_ready32", {31'd0, bus32.word_ready}, 32'd1);
        tick();
        bus32.word_valid = 1'b0;
        bus32.word_in    = $urandom;
    endtask

    task automatic drain32();
        for (int i = 0; i < 60; i++) begin
            if (q32.size() == 0 && !bus32.chunk_valid) break;
            tick();
        end
        check("drain32_left", q32.size(), 32'd0);
        check("drain32_idle", {31'd0, bus32.busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus32.word_valid = 1'b0; bus32.word_in = '0; bus32.chunk_ready = 1'b0;
        bus16.word_valid = 1'b0; bus16.word_in = '0; bus16.chunk_ready = 1'b0;

        // Reset held two cycles
        tick(); tick();
        rst = 1'b0;
        check("rst_chunk_valid", {31'd0, bus32.chunk_valid}, 32'd0);
        check("rst_busy",        {31'd0, bus32.busy},        32'd0);
        check("rst_chunk_data",  {24'd0, bus32.chunk_data},  32'd0);
        check("rst_chunk_last",  {31'd0, bus32.chunk_last},  32'd0);
        check("rst_word_ready",  {31'd0, bus32.word_ready},  32'd1);

        // Single word, consumer always ready
        bus32.chunk_ready = 1'b1;
        offer32(32'hA1B2C3D4, 4);
        check("lat_valid", {31'd0, bus32.chunk_valid}, 32'd1);
        check("lat_data",  {24'd0, bus32.chunk_data},  32'hD4);
        drain32();
        check("idle_word_ready", {31'd0, bus32.word_ready}, 32'd1);

        // Backpressure on chunk 1
        offer32(32'hA1B2C3D4, 4);
        tick();
        bus32.chunk_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_data",  {24'd0, bus32.chunk_data}, 32'hC3);
            check("bp_count", {30'd0, u32.count_q},      32'd1);
            check("bp_last",  {31'd0, bus32.chunk_last}, 32'd0);
            tick();
        end
        bus32.chunk_ready = 1'b1;
        drain32();

        // Back-to-back words, no bubble
        bus32.word_valid = 1'b1;
        bus32.word_in    = 32'h03020100;
        for (int i = 0; i < 8; i++)
            q32.push_back({(i == 3 || i == 7), 8'(i)});
        check("b2b_ready0", {31'd0, bus32.word_ready}, 32'd1);
        tick();
        bus32.word_in = 32'h07060504;
        for (int i = 0; i < 8; i++) begin
            check("b2b_valid", {31'd0, bus32.chunk_valid}, 32'd1);
            check("b2b_wready", {31'd0, bus32.word_ready}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
            tick();
            if (i == 3) bus32.word_valid = 1'b0;
        end
        drain32();

        // Reset in the middle of a word
        offer32(32'hDEADBEEF, 2);
        tick(); tick();
        check("mid_chunk2", {24'd0, bus32.chunk_data}, 32'hAD);
        bus32.chunk_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid", {31'd0, bus32.chunk_valid}, 32'd0);
        check("mid_busy",  {31'd0, bus32.busy},        32'd0);
        check("mid_q",     q32.size(),                 32'd0);
        bus32.chunk_ready = 1'b1;
        offer32(32'h11223344, 4);
        drain32();

        // 16-bit word in 4-bit chunks
        bus16.chunk_ready = 1'b1;
        bus16.word_valid  = 1'b1;
        bus16.word_in     = 16'hF00D;
        q16.push_back({1'b0, 4'hD});
        q16.push_back({1'b0, 4'h0});
        q16.push_back({1'b0, 4'h0});
        q16.push_back({1'b1, 4'hF});
        check("w16_ready", {31'd0, bus16.word_ready}, 32'd1);
        tick();
        bus16.word_valid = 1'b0;
        bus16.word_in    = 16'h5A5A;
        for (int i = 0; i < 40; i++) begin
            if (q16.size() == 0 && !bus16.chunk_valid) break;
            tick();
        end
        check("w16_left", q16.size(), 32'd0);
        check("w16_idle", {31'd0, bus16.busy}, 32'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
